led_seq_ctrl: RTL and testbench

Sequencer for the 4-LED running-light bank. It takes four debounced, active-low key levels and turns their presses into a mode: stop, left, right, or bounce. It generates the step tick at one of two selectable rates and drives the one-hot LED pattern. It sits directly after the per-key debouncers and drives the board LED pins.

---
 rtl/led_ctrl_pkg.sv | 24 ++
 rtl/led_seq_ctrl_step_tick.sv | 42 ++++
 rtl/led_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED running-light sequencer: mode values, LED reset pattern,
// bounce direction and rotate helpers.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        BOUNCE = 2'd3
    } mode_e;

    localparam logic [3:0] LED_RESET = 4'b0001;
    localparam logic       DIR_LEFT  = 1'b0;
    localparam logic       DIR_RIGHT = 1'b1;

    function automatic logic [3:0] rot_left(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    function automatic logic [3:0] rot_right(input logic [3:0] v);
        return {v[0], v[3:1]};
    endfunction

endpackage

// File: rtl/led_seq_ctrl_step_tick.sv
// Step-rate counter: counts 0..P-1 while enabled, P chosen between two periods,
// with a synchronous restart and a one-cycle tick on the last count.
module step_tick #(
    parameter int P_SLOW = 50_000_000,
    parameter int P_FAST = 12_500_000,
    parameter int CNT_W  = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    input  logic sel_fast,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(P_SLOW - 1);
    localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(P_FAST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] last_s;

    // Period select and tick decode from the registered count.
    always_comb begin
        last_s = sel_fast ? LAST_FAST : LAST_SLOW;
        tick   = en & (cnt_r == last_s);
    end

    // Counter: restart wins, held at zero when disabled, wraps on the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (restart || !en) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == last_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// 4-LED running-light sequencer: key press detect, mode FSM and one-hot LED register.
// Optional bounce mode (left+right together) is built when LED_BOUNCE_EN is defined.
module led_seq_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int STEP_SLOW = 50_000_000,
    parameter int STEP_FAST = 12_500_000,
    parameter int CNT_W     = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_stop,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_speed,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       fast,
    output logic       tick
);

    logic [3:0] keys_s;
    logic [3:0] prev_r;
    logic       armed_r;
    logic [3:0] press_s;
    logic       stop_p_s, left_p_s, right_p_s, speed_p_s;
    mode_e      mode_r, mode_nxt_s;
    logic [3:0] led_r, led_nxt_s;
    logic       fast_r;
    logic       run_s, restart_s, tick_s, step_s;
`ifdef LED_BOUNCE_EN
    logic       dir_r, dir_nxt_s;
    logic       enter_bounce_s, bounce_step_s;
`endif

    assign keys_s = {key_speed, key_right, key_left, key_stop};

    // Falling-edge press detect; the first edge after reset only primes the history,
    // so a key already held across reset release does not count as a press.
    always_comb begin
        if (armed_r) begin
            press_s = prev_r & ~keys_s;
        end else begin
            press_s = 4'b0000;
        end
        stop_p_s  = press_s[0];
        left_p_s  = press_s[1];
        right_p_s = press_s[2];
        speed_p_s = press_s[3];
    end

    // Mode next-state with press priority stop > left+right > left > right.
    always_comb begin
        mode_nxt_s = mode_r;
        if (stop_p_s) begin
            mode_nxt_s = STOP;
        end else if (left_p_s && right_p_s) begin
`ifdef LED_BOUNCE_EN
            mode_nxt_s = BOUNCE;
`else
            mode_nxt_s = LEFT;
`endif
        end else if (left_p_s) begin
            mode_nxt_s = LEFT;
        end else if (right_p_s) begin
            mode_nxt_s = RIGHT;
        end else begin
            mode_nxt_s = mode_r;
        end
    end

    // Counter control: runs in any non-stop mode, restarts on speed or a new run mode.
    always_comb begin
        run_s     = (mode_r != STOP);
        restart_s = speed_p_s | ((mode_nxt_s != mode_r) & (mode_nxt_s != STOP));
        step_s    = tick_s & ~stop_p_s;
    end

    step_tick #(
        .P_SLOW (STEP_SLOW),
        .P_FAST (STEP_FAST),
        .CNT_W  (CNT_W)
    ) u_step_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run_s),
        .restart  (restart_s),
        .sel_fast (fast_r),
        .tick     (tick_s)
    );

    // LED next pattern: shifts only on a tick that is not overridden by stop.
    always_comb begin
        led_nxt_s = led_r;
        if (step_s) begin
            case (mode_r)
                LEFT:    led_nxt_s = rot_left(led_r);
                RIGHT:   led_nxt_s = rot_right(led_r);
`ifdef LED_BOUNCE_EN
                BOUNCE: begin
                    if (dir_r == DIR_LEFT) begin
                        led_nxt_s = led_r[3] ? 4'b0100 : rot_left(led_r);
                    end else begin
                        led_nxt_s = led_r[0] ? 4'b0010 : rot_right(led_r);
                    end
                end
`endif
                default: led_nxt_s = led_r;
            endcase
        end else begin
            led_nxt_s = led_r;
        end
    end

`ifdef LED_BOUNCE_EN
    // Bounce direction: seeded on entry from the LED position, flipped at either end.
    always_comb begin
        enter_bounce_s = (mode_nxt_s == BOUNCE) && (mode_r != BOUNCE);
        bounce_step_s  = step_s && (mode_r == BOUNCE);
        if (enter_bounce_s) begin
            dir_nxt_s = led_r[3] ? DIR_RIGHT : DIR_LEFT;
        end else if (bounce_step_s && (dir_r == DIR_LEFT) && led_r[3]) begin
            dir_nxt_s = DIR_RIGHT;
        end else if (bounce_step_s && (dir_r == DIR_RIGHT) && led_r[0]) begin
            dir_nxt_s = DIR_LEFT;
        end else begin
            dir_nxt_s = dir_r;
        end
    end

    // Bounce direction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_r <= DIR_LEFT;
        end else begin
            dir_r <= dir_nxt_s;
        end
    end
`endif

    // State registers: key history, mode, speed flag and LED pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r  <= 4'b1111;
            armed_r <= 1'b0;
            mode_r  <= STOP;
            fast_r  <= 1'b0;
            led_r   <= LED_RESET;
        end else begin
            prev_r  <= keys_s;
            armed_r <= 1'b1;
            mode_r  <= mode_nxt_s;
            fast_r  <= fast_r ^ speed_p_s;
            led_r   <= led_nxt_s;
        end
    end

    assign led  = led_r;
    assign mode = mode_r;
    assign fast = fast_r;
    assign tick = tick_s;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed and random key stimulus against a
// position/phase reference model; follows LED_BOUNCE_EN the same way the design does.
module tb_led_seq_ctrl;

    localparam int P_SLOW = 8;
    localparam int P_FAST = 2;
`ifdef LED_BOUNCE_EN
    localparam bit BOUNCE_EN = 1'b1;
`else
    localparam bit BOUNCE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_stop = 1'b1, key_left = 1'b1, key_right = 1'b1, key_speed = 1'b1;
    logic [3:0] led;
    logic [1:0] mode;
    logic       fast, tick;

    led_seq_ctrl #(.STEP_SLOW(P_SLOW), .STEP_FAST(P_FAST), .CNT_W(26)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_stop(key_stop), .key_left(key_left), .key_right(key_right), .key_speed(key_speed),
        .led(led), .mode(mode), .fast(fast), .tick(tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: LED as a position 0..3, mode 0..3, cycles elapsed in the current step.
    int m_mode, m_pos, m_since;
    bit m_fast, m_dir_right, m_armed;
    bit m_prev_stop, m_prev_left, m_prev_right, m_prev_speed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_tick();
        int per;
        per = m_fast ? P_FAST : P_SLOW;
        return (m_mode != 0) && (m_since == per - 1);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_since = 0; m_fast = 1'b0; m_dir_right = 1'b0; m_armed = 1'b0;
        m_prev_stop = 1'b1; m_prev_left = 1'b1; m_prev_right = 1'b1; m_prev_speed = 1'b1;
    endtask

    task automatic model_edge();
        bit ps, pl, pr, psp, tk;
        int nm, old_pos;
        ps  = m_armed && m_prev_stop  && !key_stop;
        pl  = m_armed && m_prev_left  && !key_left;
        pr  = m_armed && m_prev_right && !key_right;
        psp = m_armed && m_prev_speed && !key_speed;
        tk  = model_tick();
        old_pos = m_pos;
        if (tk && !ps) begin
            if (m_mode == 1) m_pos = (m_pos + 1) % 4;
            else if (m_mode == 2) m_pos = (m_pos + 3) % 4;
            else if (m_mode == 3) begin
                if (!m_dir_right) begin
                    if (m_pos == 3) begin m_dir_right = 1'b1; m_pos = 2; end
                    else m_pos = m_pos + 1;
                end else begin
                    if (m_pos == 0) begin m_dir_right = 1'b0; m_pos = 1; end
                    else m_pos = m_pos - 1;
                end
            end
        end
        nm = m_mode;
        if (ps) nm = 0;
        else if (pl && pr) nm = BOUNCE_EN ? 3 : 1;
        else if (pl) nm = 1;
        else if (pr) nm = 2;
        if (nm == 3 && m_mode != 3) m_dir_right = (old_pos == 3);
        if (psp || (nm != m_mode && nm != 0)) m_since = 0;
        else if (m_mode != 0) m_since = tk ? 0 : m_since + 1;
        else m_since = 0;
        if (psp) m_fast = !m_fast;
        m_mode = nm;
        m_prev_stop = key_stop; m_prev_left = key_left;
        m_prev_right = key_right; m_prev_speed = key_speed;
        m_armed = 1'b1;
    endtask

    // Called at a negedge with keys already set: check outputs, advance model and DUT one edge.
    task automatic step();
        logic [3:0] exp_led;
        exp_led = 4'b0001 << m_pos;
        check_eq("led",  32'(led),  32'(exp_led));
        check_eq("mode", 32'(mode), 32'(m_mode));
        check_eq("fast", 32'(fast), 32'(m_fast));
        check_eq("tick", 32'(tick), 32'(model_tick()));
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One-cycle press of the selected keys (bit0 stop, bit1 left, bit2 right, bit3 speed).
    task automatic press(input logic [3:0] sel);
        key_stop = !sel[0]; key_left = !sel[1]; key_right = !sel[2]; key_speed = !sel[3];
        step();
        key_stop = 1'b1; key_left = 1'b1; key_right = 1'b1; key_speed = 1'b1;
    endtask

    task automatic do_reset();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_led",  32'(led),  32'd1);
        check_eq("rst_mode", 32'(mode), 32'd0);
        check_eq("rst_fast", 32'(fast), 32'd0);
        check_eq("rst_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;

        run(20);                          // idle: no tick, led stays 0001
        press(4'b0010); run(36);          // left: full rotation at P_SLOW
        press(4'b1000); run(10);          // speed: fast steps
        press(4'b0100); run(10);          // right: reverse
        press(4'b0001); run(12);          // stop: frozen
        press(4'b0011); run(10);          // stop+left same cycle: stop wins

        // Stop landing exactly on a tick cycle.
        press(4'b0010);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (model_tick()) found = 1'b1;
            else step();
        end
        check_eq("stop_tick_found", 32'(found), 32'd1);
        press(4'b0001); run(6);

        // Speed press on a tick cycle.
        press(4'b0100);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (model_tick()) found = 1'b1;
            else step();
        end
        check_eq("speed_tick_found", 32'(found), 32'd1);
        press(4'b1000); run(8);

        // Left+right together from the reset pattern.
        do_reset();
        press(4'b0110); run(64);
        press(4'b0110); press(4'b0100); press(4'b0110); run(20);

        // Random key activity.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(11, 0) == 0) key_stop  = !key_stop;
            if ($urandom_range(9, 0)  == 0) key_left  = !key_left;
            if ($urandom_range(9, 0)  == 0) key_right = !key_right;
            if ($urandom_range(15, 0) == 0) key_speed = !key_speed;
            step();
        end
        key_stop = 1'b1; key_left = 1'b1; key_right = 1'b1; key_speed = 1'b1;
        run(2);

        // Asynchronous reset mid-run with a key held low across release.
        press(4'b0010);
        run(int'($urandom_range(30, 5)));
        #2 rst_n = 1'b0;
        key_left = 1'b0;
        #1;
        check_eq("midrst_led",  32'(led),  32'd1);
        check_eq("midrst_mode", 32'(mode), 32'd0);
        check_eq("midrst_fast", 32'(fast), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(12);                          // key still held: no press
        key_left = 1'b1; step();
        key_left = 1'b0; step();          // fresh press
        key_left = 1'b1; run(20);
        check_eq("post_rst_mode", 32'(mode), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
